// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the fetch front end.
//   XLEN_DEFAULT / ILEN_DEFAULT : default address and instruction widths
//   INST_BYTES                  : PC step between sequential instructions
//   NOP_INST                    : canonical NOP (addi x0, x0, 0)
//   fetch_entry_t               : {pc, inst} pair held in the prefetch queue
package riscv_pkg;
  localparam int XLEN_DEFAULT = 64;
  localparam int ILEN_DEFAULT = 32;
  localparam int INST_BYTES   = 4;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [ILEN_DEFAULT-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO with first-word fall-through.
//   clk, reset  : clock, async active-high reset
//   push_i      : write wdata_i (ignored when full)
//   pop_i       : drop the head (ignored when empty)
//   flush_i     : empty the queue; overrides push and pop
//   wdata_i     : entry to enqueue
//   rdata_o     : head entry, all zeros when empty
//   count_o     : occupancy 0..DEPTH
//   full_o      : count_o == DEPTH
//   empty_o     : count_o == 0
import riscv_pkg::*;

module fetch_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  entry_t        wdata_i,
  output entry_t        rdata_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Pointers are AW bits wide so they wrap on their own (DEPTH is a power of two).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
//   clk, reset      : clock, async active-high reset
//   imem_req/addr   : fetch request and address (addr is the fetch PC)
//   imem_gnt/rdata  : grant; rdata valid in the granted cycle
//   redirect_valid  : flush queue, restart fetch at redirect_pc (word aligned)
//   inst_valid/ready: decode handshake on the queue head
//   inst_data/pc    : head instruction and its PC (zero when empty)
//   q_count         : queue occupancy
import riscv_pkg::*;

module fetch_unit #(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              ILEN     = ILEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int             CW       = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [CW-1:0]   q_count
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } entry_t;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            full, empty, push, pop;
  entry_t          wentry, head;

  // Request is withheld when full regardless of a same-cycle pop, which keeps
  // the request off the pop path.
  assign imem_req   = !reset && !full && !redirect_valid;
  assign imem_addr  = pc_q;
  assign inst_valid = !empty && !redirect_valid;

  assign push = imem_req && imem_gnt;
  assign pop  = inst_valid && inst_ready;

  assign wentry = '{pc: pc_q, inst: imem_rdata};

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    else if (push)
      pc_d = pc_q + XLEN'(INST_BYTES);  // wraps modulo 2^XLEN
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i (wentry),
    .rdata_o (head),
    .count_o (q_count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign inst_data = head.inst;
  assign inst_pc   = head.pc;
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [63:0] RPC2  = 64'hFFFF_FFFF_FFFF_FFF8;

  logic        clk = 1'b0, reset = 1'b1;
  logic        imem_req, imem_gnt, redirect_valid, inst_valid, inst_ready;
  logic [63:0] imem_addr, redirect_pc, inst_pc;
  logic [31:0] imem_rdata, inst_data;
  logic [2:0]  q_count;

  logic        req2, valid2;
  logic [63:0] addr2, pc2;
  logic [31:0] data2;
  logic [2:0]  cnt2;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(64), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .q_count(q_count));

  // Second instance exercises PC wrap from a near-top reset PC.
  fetch_unit #(.XLEN(64), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(RPC2)) dut2 (
    .clk(clk), .reset(reset), .imem_req(req2), .imem_addr(addr2),
    .imem_gnt(1'b1), .imem_rdata(32'h0), .redirect_valid(1'b0),
    .redirect_pc(64'h0), .inst_valid(valid2), .inst_ready(1'b1),
    .inst_data(data2), .inst_pc(pc2), .q_count(cnt2));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of {pc, inst} plus the next fetch address.
  typedef struct { logic [63:0] pc; logic [31:0] inst; } ent_t;
  ent_t        mq[$];
  logic [63:0] mpc;

  task automatic drive(input logic g, input logic r, input logic rv, input logic [63:0] rpc);
    imem_gnt = g; inst_ready = r; redirect_valid = rv; redirect_pc = rpc;
    imem_rdata = $urandom;
  endtask

  // Called just after a rising edge with inputs applied; checks mid-cycle,
  // advances the model, and returns just after the next rising edge.
  task automatic cycle();
    logic        e_req, e_val;
    logic [63:0] e_pc;
    logic [31:0] e_dat;
    @(negedge clk);
    e_req = (mq.size() < DEPTH) && !redirect_valid;
    e_val = (mq.size() != 0) && !redirect_valid;
    e_pc  = (mq.size() != 0) ? mq[0].pc   : 64'h0;
    e_dat = (mq.size() != 0) ? mq[0].inst : 32'h0;
    chk("imem_req",   imem_req,   e_req);
    chk("imem_addr",  imem_addr,  mpc);
    chk("inst_valid", inst_valid, e_val);
    chk("inst_pc",    inst_pc,    e_pc);
    chk("inst_data",  inst_data,  e_dat);
    chk("q_count",    q_count,    mq.size());
    if (redirect_valid) begin
      mq.delete();
      mpc = {redirect_pc[63:2], 2'b00};
    end else begin
      if (e_val && inst_ready) void'(mq.pop_front());
      if (e_req && imem_gnt) begin
        mq.push_back('{pc: mpc, inst: imem_rdata});
        mpc = mpc + 64'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Wrap check on the second instance: first four PCs seen at decode.
  logic [63:0] exp2 [4];
  int k2 = 0, cyc2 = 0;
  initial begin
    exp2[0] = RPC2; exp2[1] = RPC2 + 64'd4; exp2[2] = 64'h0; exp2[3] = 64'h4;
    wait (!reset);
    while (k2 < 4 && cyc2 < 20) begin
      @(negedge clk);
      cyc2++;
      if (valid2) begin
        chk("wrap_pc", pc2, exp2[k2]);
        k2++;
      end
    end
    if (k2 < 4) chk("wrap_timeout", 64'(k2), 64'd4);
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    #12;
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_req",   imem_req,   1'b0);
    chk("rst_count", q_count,    3'd0);
    chk("rst_pc",    inst_pc,    64'h0);
    chk("rst_data",  inst_data,  32'h0);
    chk("rst_addr",  imem_addr,  64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    mq.delete(); mpc = 64'h0;

    // Fill with decode stalled: requests stop at four entries.
    for (int i = 0; i < 6; i++) begin drive(1'b1, 1'b0, 1'b0, 64'h0); cycle(); end
    // Streaming: one instruction per cycle.
    for (int i = 0; i < 10; i++) begin drive(1'b1, 1'b1, 1'b0, 64'h0); cycle(); end
    // Alternating grant.
    for (int i = 0; i < 10; i++) begin drive(1'(i % 2 == 0), 1'b1, 1'b0, 64'h0); cycle(); end
    // Three queued entries, then a misaligned redirect.
    drive(1'b0, 1'b0, 1'b1, 64'h0); cycle();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 1'b0, 64'h0); cycle(); end
    drive(1'b0, 1'b0, 1'b1, 64'h1003); cycle();
    chk("redir_count", q_count, 3'd0);
    chk("redir_addr", imem_addr, 64'h1000);
    for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b1, 1'b0, 64'h0); cycle(); end
    // Back-to-back redirects: last wins.
    drive(1'b1, 1'b1, 1'b1, 64'h2000); cycle();
    drive(1'b1, 1'b1, 1'b1, 64'h3006); cycle();
    chk("redir_last", imem_addr, 64'h3004);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0), {$urandom, $urandom});
      cycle();
    end
    // Two entries queued, then asynchronous reset mid-cycle.
    drive(1'b0, 1'b0, 1'b1, 64'h4000); cycle();
    for (int i = 0; i < 2; i++) begin drive(1'b1, 1'b0, 1'b0, 64'h0); cycle(); end
    chk("pre_rst_count", q_count, 3'd2);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", inst_valid, 1'b0);
    chk("arst_count", q_count,    3'd0);
    chk("arst_req",   imem_req,   1'b0);
    chk("arst_addr",  imem_addr,  64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    mq.delete(); mpc = 64'h0;
    for (int i = 0; i < 8; i++) begin drive(1'b1, 1'b1, 1'b0, 64'h0); cycle(); end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end; the next generation of the core's PC/adder/instruction-memory path.
- Owns the fetch PC and issues requests to instruction memory over a req/gnt handshake.
- Buffers fetched {pc, instruction} pairs in a DEPTH-entry prefetch queue and presents them to decode over a valid/ready handshake.
- Accepts a single-cycle redirect (taken branch/jump) that flushes the queue and restarts fetch.

Parameters:
- XLEN, 64, width of PC and addresses.
- ILEN, 32, instruction width.
- DEPTH, 4, prefetch queue entries; power of two, >= 2.
- RESET_PC, 64'h0, fetch PC after reset (XLEN bits, [1:0] must be 0).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address; equals fetch_pc.
- imem_gnt  in  1  memory accepts the request; imem_rdata is valid in the same cycle when imem_req && imem_gnt.
- imem_rdata  in  ILEN  fetched instruction.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  XLEN  new fetch target.
- inst_valid  out  1  queue head is valid.
- inst_ready  in  1  decode consumes the head.
- inst_data  out  ILEN  head instruction.
- inst_pc  out  XLEN  head PC.
- q_count  out  $clog2(DEPTH)+1  current occupancy, for debug and verification.

Behaviour:
- Reset (async, takes effect immediately):
  - fetch_pc = RESET_PC; queue empty; q_count = 0.
  - inst_valid = 0, imem_req = 0, inst_data = 0, inst_pc = 0.
  - Reset asserted mid-operation discards all entries and any in-flight grant.
- Request rule: imem_req = !reset && (q_count < DEPTH) && !redirect_valid (combinational).
  - No request is issued when full, even if a pop occurs in the same cycle.
- Push: on a rising edge with imem_req && imem_gnt, enqueue {fetch_pc, imem_rdata}; fetch_pc <= fetch_pc + 4, modulo 2^XLEN (wraps to 0 after all-ones-minus-3).
- Pop: on a rising edge with inst_valid && inst_ready, the head is dequeued.
- Simultaneous push and pop: occupancy is unchanged and both take effect.
- Presentation: first-word fall-through.
  - inst_valid = (q_count != 0) && !redirect_valid.
  - inst_data / inst_pc come from the head.
  - When the queue is empty, inst_data = 0 and inst_pc = 0.
- Latency: a grant in cycle n gives inst_valid = 1 in cycle n+1 (queue was empty, no redirect). With continuous gnt and ready, throughput is 1 instruction/cycle.
- Redirect (highest priority):
  - On an edge with redirect_valid = 1: queue flushed (q_count = 0); fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - In that cycle there is no push and no pop.
  - The first request to the new target goes out the next cycle.
  - Back-to-back redirects: the last one wins.
- Pointers: read/write pointers are $clog2(DEPTH) bits and wrap naturally. Full = (q_count == DEPTH); empty = (q_count == 0).
- Invariants:
  - q_count never exceeds DEPTH.
  - There is never a pop when empty.
  - inst_pc values seen by decode increase by exactly 4 between consecutive pops unless a redirect intervenes.

Decomposition:
- Package riscv_pkg:
  - XLEN_DEFAULT = 64, ILEN_DEFAULT = 32, INST_BYTES = 4.
  - NOP_INST = 32'h00000013.
  - typedef fetch_entry_t {pc[XLEN], inst[ILEN]}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, with push, pop, flush (flush has priority), count, full and empty. It is parametrised by DEPTH and uses the same async active-high reset.
- fetch_unit contains the PC register, the request logic and redirect handling.

Test Plan:
- Reset release, gnt held 1, ready held 0 → imem_addr issues 0,4,8,12. imem_req drops once q_count = 4. inst_pc stays 0 with inst_data equal to the first rdata.
- gnt = 1 and ready = 1 continuously → one pop per cycle with inst_pc 0,4,8,…; q_count stays at 1 after the first cycle.
- gnt toggled 1,0,1,0 with ready = 1 → fetch_pc advances only on grant cycles. No duplicate or skipped PCs at decode, and no pop when empty.
- Queue holds 3 entries, then redirect_valid for one cycle with redirect_pc = 64'h1003 → that cycle inst_valid = 0; q_count = 0 after the edge; the next imem_addr = 64'h1000; the next popped inst_pc = 64'h1000.
- RESET_PC = 64'hFFFF_FFFF_FFFF_FFF8, gnt = ready = 1 → fetched PCs are …FFF8, …FFFC, 0, 4.
- reset asserted asynchronously mid-stream with q_count = 2 → immediately inst_valid = 0, q_count = 0, imem_req = 0. After release, fetch restarts at RESET_PC.
